// File: rtl/maze_vram_arbiter_if.sv
// Bundle of every signal the tile-RAM arbiter exchanges with its neighbours:
// VGA counters, writer and reader handshakes, display fetch output and the
// single-port RAM bus.
//   master : the surrounding system (sync generator, users, RAM)
//   slave  : the arbiter itself
interface maze_vram_arbiter_if;
  logic [9:0]  counter_x;
  logic [9:0]  counter_y;

  logic        wr_req;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack;

  logic        rd_req;
  logic [10:0] rd_addr;
  logic        rd_ack;
  logic [3:0]  rd_data;

  logic        disp_vld;
  logic [3:0]  disp_tile;
  logic [5:0]  disp_col;
  logic [4:0]  disp_row;

  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;

  modport master (
    output counter_x, counter_y,
    output wr_req, wr_addr, wr_data,
    input  wr_ack,
    output rd_req, rd_addr,
    input  rd_ack, rd_data,
    input  disp_vld, disp_tile, disp_col, disp_row,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  counter_x, counter_y,
    input  wr_req, wr_addr, wr_data,
    output wr_ack,
    input  rd_req, rd_addr,
    output rd_ack, rd_data,
    output disp_vld, disp_tile, disp_col, disp_row,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/maze_vram_arbiter.sv
// Arbiter sharing one single-port synchronous tile RAM (40x30 tiles, 4-bit code)
// between the VGA tile fetch, a game-logic writer and a collision reader.
// Display fetches own fixed slots and always win; writer and reader share the
// remaining cycles round-robin. Every access completes exactly 3 cycles after
// its decision cycle (RAM bus registered, RAM data one cycle later, result
// registered).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of maze_vram_arbiter_if (counters, wr/rd handshakes,
//          display fetch output, RAM bus)
module maze_vram_arbiter #(
  parameter logic [3:0]  DISP_SLOT = 4'd12,
  parameter logic [9:0]  PRE_X     = 10'd796,
  parameter logic [9:0]  V_LAST    = 10'd521,
  parameter logic [10:0] N_TILES   = 11'd1200
) (
  input logic               clk,
  input logic               reset,
  maze_vram_arbiter_if.slave bus
);

  // Decision-cycle signals
  logic        dispA, dispB, dispGo;
  logic [9:0]  nextY;
  logic [5:0]  dCol;
  logic [4:0]  dRow;
  logic [10:0] dAddr;
  logic        wrElig, rdElig, grantW, grantR;
  logic [10:0] selAddr;
  logic        inRange;

  // Pipeline and output state
  logic        ramEn, ramWe;
  logic [10:0] ramAddr;
  logic [3:0]  ramWdata;
  logic        s1Disp, s1Wr, s1Rd, s1Zero;
  logic [5:0]  s1Col;
  logic [4:0]  s1Row;
  logic        s2Disp, s2Wr, s2Rd, s2Zero;
  logic [5:0]  s2Col;
  logic [4:0]  s2Row;
  logic        wrAck, rdAck, dispVld;
  logic [3:0]  rdData, dispTile;
  logic [5:0]  dispCol;
  logic [4:0]  dispRow;
  logic        wrBusy, rdBusy;
  logic        rrPtr;  // 0: writer preferred, 1: reader preferred

  always_comb begin
    // Columns 1..39 are fetched one tile ahead; 624 = 39*16 stops after column 39.
    dispA  = (bus.counter_x[3:0] == DISP_SLOT) && (bus.counter_x < 10'd624) &&
             (bus.counter_y < 10'd480);
    nextY  = (bus.counter_y == V_LAST) ? 10'd0 : bus.counter_y + 10'd1;
    // Column 0 of the next line is prefetched at the end of the current one.
    dispB  = (bus.counter_x == PRE_X) && (nextY < 10'd480);
    dispGo = dispA | dispB;
    dCol   = dispA ? bus.counter_x[9:4] + 6'd1 : 6'd0;
    dRow   = dispA ? bus.counter_y[8:4] : nextY[8:4];
    // row*40 + col
    dAddr  = {1'b0, dRow, 5'b0} + {3'b0, dRow, 3'b0} + {5'b0, dCol};

    wrElig  = bus.wr_req & ~wrBusy;
    rdElig  = bus.rd_req & ~rdBusy;
    grantW  = ~dispGo & wrElig & (~rdElig | ~rrPtr);
    grantR  = ~dispGo & rdElig & (~wrElig | rrPtr);
    selAddr = grantW ? bus.wr_addr : bus.rd_addr;
    inRange = selAddr < N_TILES;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramEn    <= 1'b0;
      ramWe    <= 1'b0;
      ramAddr  <= 11'd0;
      ramWdata <= 4'd0;
      s1Disp   <= 1'b0;
      s1Wr     <= 1'b0;
      s1Rd     <= 1'b0;
      s1Zero   <= 1'b0;
      s1Col    <= 6'd0;
      s1Row    <= 5'd0;
      s2Disp   <= 1'b0;
      s2Wr     <= 1'b0;
      s2Rd     <= 1'b0;
      s2Zero   <= 1'b0;
      s2Col    <= 6'd0;
      s2Row    <= 5'd0;
      wrAck    <= 1'b0;
      rdAck    <= 1'b0;
      rdData   <= 4'd0;
      dispVld  <= 1'b0;
      dispTile <= 4'd0;
      dispCol  <= 6'd0;
      dispRow  <= 5'd0;
      wrBusy   <= 1'b0;
      rdBusy   <= 1'b0;
      rrPtr    <= 1'b0;
    end else begin
      // Out-of-range requests still flow down the pipeline but never touch the RAM.
      ramEn    <= dispGo | ((grantW | grantR) & inRange);
      ramWe    <= grantW & inRange;
      ramAddr  <= dispGo ? dAddr : ((grantW | grantR) ? selAddr : 11'd0);
      ramWdata <= grantW ? bus.wr_data : 4'd0;

      s1Disp <= dispGo;
      s1Wr   <= grantW;
      s1Rd   <= grantR;
      s1Zero <= grantR & ~inRange;
      s1Col  <= dCol;
      s1Row  <= dRow;

      s2Disp <= s1Disp;
      s2Wr   <= s1Wr;
      s2Rd   <= s1Rd;
      s2Zero <= s1Zero;
      s2Col  <= s1Col;
      s2Row  <= s1Row;

      wrAck   <= s2Wr;
      rdAck   <= s2Rd;
      rdData  <= (s2Rd & ~s2Zero) ? bus.ram_rdata : 4'd0;
      dispVld <= s2Disp;
      if (s2Disp) begin
        dispTile <= bus.ram_rdata;
        dispCol  <= s2Col;
        dispRow  <= s2Row;
      end

      // Busy covers grant through ack so a held req is not re-granted.
      if (grantW)     wrBusy <= 1'b1;
      else if (wrAck) wrBusy <= 1'b0;
      if (grantR)     rdBusy <= 1'b1;
      else if (rdAck) rdBusy <= 1'b0;

      if (grantW)      rrPtr <= 1'b1;
      else if (grantR) rrPtr <= 1'b0;
    end
  end

  assign bus.ram_en    = ramEn;
  assign bus.ram_we    = ramWe;
  assign bus.ram_addr  = ramAddr;
  assign bus.ram_wdata = ramWdata;
  assign bus.wr_ack    = wrAck;
  assign bus.rd_ack    = rdAck;
  assign bus.rd_data   = rdData;
  assign bus.disp_vld  = dispVld;
  assign bus.disp_tile = dispTile;
  assign bus.disp_col  = dispCol;
  assign bus.disp_row  = dispRow;

endmodule

// File: doc/maze_vram_arbiter.md
Name: maze_vram_arbiter

Overview:
Shares one single-port synchronous tile RAM (40x30 maze tiles, 4-bit tile code, 1200 words) between three users: the VGA display tile fetch, a game-logic writer, and a collision-check reader. Sits beside the VGA sync generator and consumes its 10-bit pixel column/line counters.
- Display fetch owns fixed cycles and always wins.
- Writer and reader share every other cycle under round-robin arbitration with req/ack handshakes.
- The downstream pixel renderer consumes the fetched tile code.

Parameters:
DISP_SLOT, 12, value of counter_x[3:0] on which a column 1..39 display fetch is issued
PRE_X, 796, counter_x value on which the column-0 fetch for the next line is issued
V_LAST, 521, last line value of counter_y before wrap to 0
N_TILES, 1200, number of valid RAM words; addresses >= N_TILES are out of range

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
counter_x  in  10  pixel column counter from sync generator (0..800)
counter_y  in  10  line counter from sync generator (0..V_LAST)
wr_req  in  1  writer request; held with addr/data stable until wr_ack
wr_addr  in  11  writer tile address
wr_data  in  4  writer tile code
wr_ack  out  1  one-cycle write completion pulse
rd_req  in  1  reader request; held with addr stable until rd_ack
rd_addr  in  11  reader tile address
rd_ack  out  1  one-cycle read completion pulse
rd_data  out  4  read tile code, valid while rd_ack=1
disp_vld  out  1  one-cycle pulse: display tile fetched
disp_tile  out  4  fetched tile code, valid with disp_vld, held until next disp_vld
disp_col  out  6  tile column of disp_tile (0..39)
disp_row  out  5  tile row of disp_tile (0..29)
ram_en  out  1  RAM access enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  11  RAM address (registered)
ram_wdata  out  4  RAM write data (registered)
ram_rdata  in  4  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; busy flags cleared; round-robin pointer points to the writer; pipeline contents discarded, so no ack or disp_vld is issued for operations that were in flight.
- Decision cycle D. Owner is chosen combinationally from the inputs in cycle D, in this priority order:
  1. Display slot, case a: counter_x[3:0]==DISP_SLOT and counter_x<624 and counter_y<480. Column = counter_x[9:4]+1; row = counter_y[9:4].
  2. Display slot, case b: counter_x==PRE_X. Next line ny = (counter_y==V_LAST) ? 0 : counter_y+1. Column = 0; row = ny[9:4]. The slot is used only if ny<480; otherwise the cycle is free.
  3. Otherwise, eligible requesters (req=1 and not busy) get round-robin service. If both are eligible, the one the pointer selects wins, and the pointer toggles to the other after each grant. If only one is eligible, it wins.
  4. Otherwise, idle: ram_en=0 in D+1.
- Pipeline:
  - ram_* registered, visible in D+1.
  - ram_rdata valid in D+2.
  - ack/rd_data/disp_* registered, asserted in D+3.
  - Fixed latency of 3 cycles from decision to completion. Up to 3 operations in flight.
- Display timing: a fetch decided at x[3:0]==12 gives disp_vld at x[3:0]==15. The column-0 fetch decided at x=796 gives disp_vld at x=799.
- Address = row*40 + col, computed as (row<<5)+(row<<3)+col, 11 bits.
- Busy: a requester's busy flag is set at its grant (D) and cleared after its ack cycle. req is ignored during D..D+3, so the earliest re-grant is D+4. A requester must drop req in the cycle after ack unless it issues a new request.
- Out-of-range address (>= N_TILES):
  - Write: ram_en stays 0; wr_ack is still pulsed at D+3.
  - Read: rd_ack is pulsed at D+3 with rd_data=0.
- Write and read to the same address granted in consecutive cycles: the RAM order defines the result. The read returns the new data if the write was granted first.
- Starvation bound: display uses at most 1 in 16 cycles and the two requesters alternate. Worst-case req-to-grant delay is 2 cycles; req-to-ack is 5 cycles.
- req dropped before grant is legal and cancels the request; req dropped after grant does not abort the operation.

Test Plan:
1. Reset: hold reset=0 with wr_req=1 → all outputs 0, no RAM access. Release reset → first grant occurs within 2 cycles.
2. Write then read: wr_req to addr 85 (row 2, col 5) with data 0x9 → ram_we=1, ram_addr=85 one cycle after grant; wr_ack 3 cycles after grant. Then rd_req addr 85 → rd_ack with rd_data=0x9.
3. Display sweep: run counters through line 37 with RAM preloaded so addr 80+c holds c[3:0] →
   - disp_vld at x=799 of line 36 with col 0, row 2;
   - then at x[3:0]==15 for x<640, cols 1..39, disp_tile = col[3:0].
   - No disp_vld on lines 480..V_LAST except the column-0 fetch at V_LAST, which gives row 0.
4. Collision with display slot: wr_req and rd_req both asserted at x=12, line 0 → display gets x=12, writer x=13, reader x=14; acks at x=16 and x=17.
5. Round-robin fairness: both requesters continuously re-request during blanking → grants alternate W,R,W,R; no requester is granted twice in a row while the other is eligible.
6. Out-of-range and reset mid-flight: rd_addr 1200 → rd_ack with rd_data=0 and ram_en never 1. Then grant a write, assert reset at D+1 → no wr_ack ever appears.
